// File: rtl/d_fifo_drain_arbiter_pkg.sv
// rtl/d_fifo_drain_arbiter_pkg.sv - shared types and constants for the D-FIFO drain arbiter
package d_fifo_drain_arbiter_pkg;

  localparam int DEFAULT_DATA_W = 6;

  // Channel ids carried in the top bit of every merged word
  localparam logic CH_D0 = 1'b0;
  localparam logic CH_D1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/d_fifo_drain_arbiter_merge_skid_buf.sv
// rtl/d_fifo_drain_arbiter_merge_skid_buf.sv - 2-entry output skid buffer for the merged stream
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   s_tvalid, s_tdata enqueue port (write to tail)
//   m_tvalid, m_tdata head entry, valid whenever occ != 0
//   m_tready          downstream accepts the head entry
//   occ               number of buffered entries (0..2)
module merge_skid_buf #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_tvalid,
  input  logic [W-1:0] s_tdata,
  output logic         m_tvalid,
  output logic [W-1:0] m_tdata,
  input  logic         m_tready,
  output logic [1:0]   occ
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push;
  logic         pop;

  assign m_tvalid = (occ != 2'd0);
  assign m_tdata  = mem[rd_ptr];
  assign pop      = m_tvalid & m_tready;
  // Upstream credit keeps this from ever seeing a push into a full buffer
  // without a simultaneous pop; the guard just keeps the state consistent.
  assign push     = s_tvalid & ((occ != 2'd2) | pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_tdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/d_fifo_drain_arbiter.sv
// rtl/d_fifo_drain_arbiter.sv - round-robin drain of D0/D1 FIFOs into one tagged stream
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   enable                      allow new pops (buffered/in-flight words still drain)
//   fifo_empty_d0/d1            source FIFO empty flags
//   data_out_0/1                source FIFO read data, valid the cycle after a pop
//   pop_d0/pop_d1               pop strobes (combinational, at most one per cycle)
//   ready_in                    downstream accepts merged word
//   valid_out, merged_out       merged stream, merged_out = {channel_id, data}
//   count_d0/count_d1           saturating delivered-word counters
//   idle_out                    FSM is in IDLE
module d_fifo_drain_arbiter
  import d_fifo_drain_arbiter_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty_d0,
  input  logic              fifo_empty_d1,
  input  logic [DATA_W-1:0] data_out_0,
  input  logic [DATA_W-1:0] data_out_1,
  output logic              pop_d0,
  output logic              pop_d1,
  input  logic              ready_in,
  output logic              valid_out,
  output logic [DATA_W:0]   merged_out,
  output logic [CNT_W-1:0]  count_d0,
  output logic [CNT_W-1:0]  count_d1,
  output logic              idle_out
);

  localparam logic [2:0]       DEPTH_L = 3'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t      state;
  state_t      state_n;
  logic        last_grant;
  logic        inflight;
  logic        inflight_ch;
  logic        gnt_ch;
  logic        pop_any;
  logic        deq;
  logic        credit_ok;
  logic        d0_rdy;
  logic        d1_rdy;
  logic        any_rdy;
  logic        head_ch;
  logic [1:0]  occ;
  logic [DATA_W:0] enq_data;

  assign d0_rdy  = !fifo_empty_d0;
  assign d1_rdy  = !fifo_empty_d1;
  assign any_rdy = d0_rdy | d1_rdy;
  assign deq     = valid_out & ready_in;
  assign head_ch = merged_out[DATA_W];

  // A word popped now lands in the buffer next cycle; count it against the
  // space that will exist then, crediting a dequeue happening this cycle.
  assign credit_ok = ({1'b0, occ} + {2'b00, inflight}) < (DEPTH_L + {2'b00, deq});

  always_comb begin
    gnt_ch = CH_D0;
    if (d0_rdy && d1_rdy) begin
      gnt_ch = ~last_grant;
    end else if (d1_rdy) begin
      gnt_ch = CH_D1;
    end
  end

  assign pop_any = !reset && (state == ST_RUN) && enable && any_rdy && credit_ok;
  assign pop_d0  = pop_any && (gnt_ch == CH_D0);
  assign pop_d1  = pop_any && (gnt_ch == CH_D1);

  assign enq_data = {inflight_ch, (inflight_ch == CH_D1) ? data_out_1 : data_out_0};

  merge_skid_buf #(
    .W(DATA_W + 1)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .s_tvalid (inflight),
    .s_tdata  (enq_data),
    .m_tvalid (valid_out),
    .m_tdata  (merged_out),
    .m_tready (ready_in),
    .occ      (occ)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (enable && any_rdy) state_n = ST_RUN;
      ST_RUN:   if (!enable || !any_rdy) state_n = ST_DRAIN;
      ST_DRAIN: if (occ == 2'd0 && !inflight) state_n = (enable && any_rdy) ? ST_RUN : ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  assign idle_out = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_grant  <= CH_D1;
      inflight    <= 1'b0;
      inflight_ch <= CH_D0;
      count_d0    <= '0;
      count_d1    <= '0;
    end else begin
      state    <= state_n;
      inflight <= pop_any;
      if (pop_any) begin
        last_grant  <= gnt_ch;
        inflight_ch <= gnt_ch;
      end
      if (deq) begin
        if (head_ch == CH_D1) begin
          if (count_d1 != CNT_MAX) count_d1 <= count_d1 + CNT_W'(1);
        end else begin
          if (count_d0 != CNT_MAX) count_d0 <= count_d0 + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_d_fifo_drain_arbiter.sv
// tb/tb_d_fifo_drain_arbiter.sv - scoreboard bench for d_fifo_drain_arbiter
module tb_d_fifo_drain_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       fifo_empty_d0 = 1'b1;
  logic       fifo_empty_d1 = 1'b1;
  logic       ready_in = 1'b0;
  logic [5:0] data_out_0 = '0;
  logic [5:0] data_out_1 = '0;
  logic       pop_d0;
  logic       pop_d1;
  logic       valid_out;
  logic       idle_out;
  logic [6:0] merged_out;
  logic [7:0] count_d0;
  logic [7:0] count_d1;

  int n_cmp = 0;
  int n_err = 0;
  int n_deliv = 0;

  logic [5:0] q0 [$];
  logic [5:0] q1 [$];
  logic [6:0] exp_q [$];

  logic       prev_stall = 1'b0;
  logic [6:0] prev_word = '0;
  logic [6:0] exp_w;

  always #5 clk = ~clk;

  d_fifo_drain_arbiter #(
    .DATA_W(6), .BUF_DEPTH(2), .CNT_W(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .fifo_empty_d0 (fifo_empty_d0),
    .fifo_empty_d1 (fifo_empty_d1),
    .data_out_0    (data_out_0),
    .data_out_1    (data_out_1),
    .pop_d0        (pop_d0),
    .pop_d1        (pop_d1),
    .ready_in      (ready_in),
    .valid_out     (valid_out),
    .merged_out    (merged_out),
    .count_d0      (count_d0),
    .count_d1      (count_d1),
    .idle_out      (idle_out)
  );

  // Source FIFO models: one-cycle read latency, flags refreshed at each edge
  always @(posedge clk) begin
    if (pop_d0 && pop_d1) begin
      n_cmp++; n_err++;
      $display("FAIL dual_pop: pop_d0=1 pop_d1=1, required at most one");
    end
    if (pop_d0) begin
      n_cmp++;
      if (fifo_empty_d0) begin
        n_err++; $display("FAIL pop_empty_d0: pop_d0=1 with empty flag 1, required 0");
      end else if (q0.size() != 0) data_out_0 <= q0.pop_front();
    end
    if (pop_d1) begin
      n_cmp++;
      if (fifo_empty_d1) begin
        n_err++; $display("FAIL pop_empty_d1: pop_d1=1 with empty flag 1, required 0");
      end else if (q1.size() != 0) data_out_1 <= q1.pop_front();
    end
    fifo_empty_d0 <= (q0.size() == 0);
    fifo_empty_d1 <= (q1.size() == 0);
  end

  // Output scoreboard and hold-while-stalled monitor
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_cmp++;
        if (valid_out !== 1'b1 || merged_out !== prev_word) begin
          n_err++;
          $display("FAIL hold: valid=%b word=%h, required valid=1 word=%h", valid_out, merged_out, prev_word);
        end
      end
      if (valid_out && ready_in) begin
        n_cmp++; n_deliv++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL unexpected_word: got %h, required no delivery", merged_out);
        end else begin
          exp_w = exp_q.pop_front();
          if (merged_out !== exp_w) begin
            n_err++; $display("FAIL merged_word: got %h, required %h", merged_out, exp_w);
          end
        end
      end
      prev_stall = valid_out && !ready_in;
      prev_word  = merged_out;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; ready_in = 1'b0;
    q0.delete(); q1.delete();
    step(); step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_cmp++;
    if (pop_d0 !== 1'b0 || pop_d1 !== 1'b0 || valid_out !== 1'b0 || merged_out !== 7'h00 ||
        count_d0 !== 8'h00 || count_d1 !== 8'h00 || idle_out !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: pops=%b%b valid=%b word=%h c0=%h c1=%h idle=%b, required 00 0 00 00 00 1",
               pop_d0, pop_d1, valid_out, merged_out, count_d0, count_d1, idle_out);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (idle_out !== 1'b1 || valid_out !== 1'b0) begin
      n_err++; $display("FAIL reset_release: idle=%b valid=%b, required 1 0", idle_out, valid_out);
    end
  endtask

  task automatic test_single_channel();
    logic [11:0] pv, p1v, vv, iv;
    do_reset();
    q0.push_back(6'h2C); q0.push_back(6'h2D); q0.push_back(6'h2E);
    exp_q.push_back(7'h2C); exp_q.push_back(7'h2D); exp_q.push_back(7'h2E);
    step();
    enable = 1'b1; ready_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      pv[i] = pop_d0; p1v[i] = pop_d1; vv[i] = valid_out; iv[i] = idle_out;
      step();
    end
    n_cmp++;
    if (pv !== 12'h00E || p1v !== 12'h000) begin
      n_err++; $display("FAIL single_pops: d0=%h d1=%h, required d0=00e d1=000", pv, p1v);
    end
    n_cmp++;
    if (vv !== 12'h038) begin
      n_err++; $display("FAIL single_valid: got %h, required 038", vv);
    end
    n_cmp++;
    if (iv !== 12'hF81) begin
      n_err++; $display("FAIL single_idle: got %h, required f81", iv);
    end
    n_cmp++;
    if (count_d0 !== 8'd3 || exp_q.size() != 0) begin
      n_err++; $display("FAIL single_count: c0=%0d left=%0d, required 3 0", count_d0, exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] ord;
    int npop;
    do_reset();
    q0.push_back(6'h01); q0.push_back(6'h02);
    q1.push_back(6'h11); q1.push_back(6'h12);
    exp_q.push_back(7'h01); exp_q.push_back(7'h51); exp_q.push_back(7'h02); exp_q.push_back(7'h52);
    step();
    enable = 1'b1; ready_in = 1'b1;
    ord = '0; npop = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (pop_d0 || pop_d1) begin
        ord = {ord[2:0], pop_d1};
        npop++;
      end
      step();
    end
    n_cmp++;
    if (npop != 4 || ord !== 4'b0101) begin
      n_err++; $display("FAIL rr_order: pops=%0d order=%b, required 4 0101", npop, ord);
    end
    n_cmp++;
    if (count_d0 !== 8'd2 || count_d1 !== 8'd2 || exp_q.size() != 0) begin
      n_err++; $display("FAIL rr_counts: c0=%0d c1=%0d left=%0d, required 2 2 0", count_d0, count_d1, exp_q.size());
    end
  endtask

  task automatic test_back_pressure();
    int npop;
    int k;
    do_reset();
    q0.push_back(6'h05); q0.push_back(6'h06); q0.push_back(6'h07);
    q1.push_back(6'h15); q1.push_back(6'h16); q1.push_back(6'h17);
    exp_q.push_back(7'h05); exp_q.push_back(7'h55); exp_q.push_back(7'h06);
    exp_q.push_back(7'h56); exp_q.push_back(7'h07); exp_q.push_back(7'h57);
    step();
    enable = 1'b1; ready_in = 1'b0;
    npop = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      npop += int'(pop_d0) + int'(pop_d1);
      step();
    end
    n_cmp++;
    if (npop != 2) begin
      n_err++; $display("FAIL bp_pops: got %0d, required 2", npop);
    end
    n_cmp++;
    if (valid_out !== 1'b1 || merged_out !== 7'h05) begin
      n_err++; $display("FAIL bp_head: valid=%b word=%h, required 1 05", valid_out, merged_out);
    end
    ready_in = 1'b1;
    for (k = 0; k < 40 && exp_q.size() != 0; k++) step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL bp_timeout: %0d words undelivered, required 0", exp_q.size());
    end
    step(); step(); step();
    n_cmp++;
    if (count_d0 !== 8'd3 || count_d1 !== 8'd3 || idle_out !== 1'b1) begin
      n_err++; $display("FAIL bp_counts: c0=%0d c1=%0d idle=%b, required 3 3 1", count_d0, count_d1, idle_out);
    end
  endtask

  task automatic test_enable_drop();
    logic [9:0] pv, iv;
    do_reset();
    q0.push_back(6'h21); q0.push_back(6'h22); q0.push_back(6'h23);
    exp_q.push_back(7'h21); exp_q.push_back(7'h22);
    step();
    enable = 1'b1; ready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) enable = 1'b0;
      #1;
      pv[i] = pop_d0 | pop_d1; iv[i] = idle_out;
      step();
    end
    n_cmp++;
    if (pv !== 10'h006) begin
      n_err++; $display("FAIL drop_pops: got %h, required 006", pv);
    end
    n_cmp++;
    if (iv !== 10'h3C1) begin
      n_err++; $display("FAIL drop_idle: got %h, required 3c1", iv);
    end
    n_cmp++;
    if (exp_q.size() != 0 || q0.size() != 1 || count_d0 !== 8'd2) begin
      n_err++; $display("FAIL drop_words: left=%0d fifo=%0d c0=%0d, required 0 1 2", exp_q.size(), q0.size(), count_d0);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    q0.delete();
    q0.push_back(6'h31); q0.push_back(6'h32); q0.push_back(6'h33);
    ready_in = 1'b0;
    step();
    enable = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (valid_out !== 1'b1 || count_d0 !== 8'd2) begin
      n_err++; $display("FAIL mid_pre: valid=%b c0=%0d, required 1 2", valid_out, count_d0);
    end
    reset = 1'b1; enable = 1'b0;
    exp_q.delete();
    step();
    n_cmp++;
    if (valid_out !== 1'b0 || count_d0 !== 8'd0 || count_d1 !== 8'd0 || idle_out !== 1'b1 || merged_out !== 7'h00) begin
      n_err++;
      $display("FAIL mid_reset: valid=%b c0=%0d c1=%0d idle=%b word=%h, required 0 0 0 1 00",
               valid_out, count_d0, count_d1, idle_out, merged_out);
    end
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      seen = seen | valid_out | pop_d0 | pop_d1;
      step();
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL mid_ignore: activity=%b after reset, required 0", seen);
    end
  endtask

  task automatic test_saturate();
    int k;
    do_reset();
    n_deliv = 0;
    for (int i = 0; i < 260; i++) begin
      q1.push_back(6'(i));
      exp_q.push_back({1'b1, 6'(i)});
    end
    step();
    enable = 1'b1; ready_in = 1'b1;
    for (k = 0; k < 400 && exp_q.size() != 0; k++) step();
    step(); step(); step();
    n_cmp++;
    if (exp_q.size() != 0 || n_deliv != 260) begin
      n_err++; $display("FAIL sat_deliver: left=%0d delivered=%0d, required 0 260", exp_q.size(), n_deliv);
    end
    n_cmp++;
    if (count_d1 !== 8'd255 || count_d0 !== 8'd0) begin
      n_err++; $display("FAIL sat_count: c1=%0d c0=%0d, required 255 0", count_d1, count_d0);
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_round_robin();
    test_back_pressure();
    test_enable_drop();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
